// File: rtl/handshake_arb_pkg.sv
// Shared types and default sizing for the 4-phase handshake arbiter.
package handshake_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        ACK_HI = 2'd2,
        REQ_LO = 2'd3
    } arb_state_e;

    localparam int N_REQ_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchronizer for signals asynchronous to clk.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter merging N 4-phase requesters onto one downstream channel.
//   state  | meaning
//   IDLE   | waiting for any synchronized request; picks a winner round-robin
//   REQ_HI | req_out raised, waiting for downstream ack to rise
//   ACK_HI | winner acknowledged, waiting for its request to fall
//   REQ_LO | req_out dropped, waiting for downstream ack to fall
module handshake_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int IW         = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] ack_in,
    output logic             req_out,
    input  logic             ack_out,
    output logic [IW-1:0]    grant_id,
    output logic             busy,
    output logic             proto_err
);

    logic [N_REQ-1:0] sreq;
    logic             sack;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req_sync
        sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (req_in[g]),
            .q_o (sreq[g])
        );
    end

    sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ack_out),
        .q_o (sack)
    );

    // Lowest offset from last+1 wins; iterating downward lets the nearest one overwrite.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IW-1:0]    last);
        logic [IW-1:0] sel;
        logic [IW-1:0] cand;
        int            idx;
        sel = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx  = (int'(last) + i) % N_REQ;
            cand = IW'(idx);
            if (r[cand]) sel = cand;
        end
        return sel;
    endfunction

    arb_state_e       state_q;
    logic [N_REQ-1:0] ack_in_q;
    logic             req_out_q;
    logic [IW-1:0]    grant_id_q;
    logic [IW-1:0]    last_grant_q;
    logic             proto_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ack_in_q     <= '0;
            req_out_q    <= 1'b0;
            grant_id_q   <= '0;
            last_grant_q <= IW'(N_REQ - 1);
            proto_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sack) proto_err_q <= 1'b1;
                    if (|sreq) begin
                        grant_id_q <= rr_pick(sreq, last_grant_q);
                        req_out_q  <= 1'b1;
                        state_q    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (!sreq[grant_id_q]) proto_err_q <= 1'b1;
                    if (sack) begin
                        ack_in_q[grant_id_q] <= 1'b1;
                        state_q              <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (!sreq[grant_id_q]) begin
                        req_out_q <= 1'b0;
                        state_q   <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!sack) begin
                        ack_in_q     <= '0;
                        last_grant_q <= grant_id_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_in    = ack_in_q;
    assign req_out   = req_out_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed vector table plus hand sequences for the 4-phase round-robin arbiter.
module tb_handshake_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] ack_in;
    logic       req_out;
    logic       ack_out;
    logic [1:0] grant_id;
    logic       busy;
    logic       proto_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    handshake_arbiter #(.N_REQ(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .ack_in    (ack_in),
        .req_out   (req_out),
        .ack_out   (ack_out),
        .grant_id  (grant_id),
        .busy      (busy),
        .proto_err (proto_err)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic       ack;
        int         edges;
        logic       ro;
        logic [3:0] ai;
        logic [1:0] gid;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after each; ack_in must never be multi-hot.
    task automatic edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk("ack_in_onehot", 32'($countones(ack_in) <= 1), 32'd1);
        end
    endtask

    task automatic chk_all(input string nm, input logic ro, input logic [3:0] ai,
                           input logic [1:0] gid, input logic bz, input logic er);
        chk({nm, ".req_out"},   32'(req_out),   32'(ro));
        chk({nm, ".ack_in"},    32'(ack_in),    32'(ai));
        chk({nm, ".grant_id"},  32'(grant_id),  32'(gid));
        chk({nm, ".busy"},      32'(busy),      32'(bz));
        chk({nm, ".proto_err"}, 32'(proto_err), 32'(er));
    endtask

    task automatic do_reset();
        rst = 1'b1; req_in = '0; ack_out = 1'b0;
        edges(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_in = '0; ack_out = 1'b0;

        //        name          rst req      ack edges ro  ai       gid   busy err
        vt.push_back('{"reset",     1, 4'b0000, 0, 2, 0, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{"sr_lat2",   0, 4'b0100, 0, 2, 0, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{"sr_lat3",   0, 4'b0100, 0, 1, 1, 4'b0000, 2'd2, 1, 0});
        vt.push_back('{"sr_ack2",   0, 4'b0100, 1, 2, 1, 4'b0000, 2'd2, 1, 0});
        vt.push_back('{"sr_ack3",   0, 4'b0100, 1, 1, 1, 4'b0100, 2'd2, 1, 0});
        vt.push_back('{"sr_reqlo",  0, 4'b0000, 1, 3, 0, 4'b0100, 2'd2, 1, 0});
        vt.push_back('{"sr_done",   0, 4'b0000, 0, 3, 0, 4'b0000, 2'd2, 0, 0});
        vt.push_back('{"lg_grant",  0, 4'b1011, 0, 3, 1, 4'b0000, 2'd3, 1, 0});
        vt.push_back('{"lg_ack",    0, 4'b1011, 1, 3, 1, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{"lg_reqlo",  0, 4'b0000, 1, 3, 0, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{"lg_done",   0, 4'b0000, 0, 3, 0, 4'b0000, 2'd3, 0, 0});
        vt.push_back('{"reset2",    1, 4'b0000, 0, 1, 0, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{"ct_grant1", 0, 4'b1010, 0, 3, 1, 4'b0000, 2'd1, 1, 0});
        vt.push_back('{"ct_ack1",   0, 4'b1010, 1, 3, 1, 4'b0010, 2'd1, 1, 0});
        vt.push_back('{"ct_reqlo1", 0, 4'b1000, 1, 3, 0, 4'b0010, 2'd1, 1, 0});
        vt.push_back('{"ct_done1",  0, 4'b1000, 0, 3, 0, 4'b0000, 2'd1, 0, 0});
        vt.push_back('{"ct_grant3", 0, 4'b1000, 0, 1, 1, 4'b0000, 2'd3, 1, 0});
        vt.push_back('{"ct_ack3",   0, 4'b1000, 1, 3, 1, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{"ct_reqlo3", 0, 4'b0001, 1, 3, 0, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{"wr_done3",  0, 4'b1001, 0, 3, 0, 4'b0000, 2'd3, 0, 0});
        vt.push_back('{"wr_grant0", 0, 4'b1001, 0, 1, 1, 4'b0000, 2'd0, 1, 0});
        vt.push_back('{"wr_ack0",   0, 4'b1001, 1, 3, 1, 4'b0001, 2'd0, 1, 0});
        vt.push_back('{"wr_reqlo0", 0, 4'b1000, 1, 3, 0, 4'b0001, 2'd0, 1, 0});
        vt.push_back('{"wr_done0",  0, 4'b1000, 0, 3, 0, 4'b0000, 2'd0, 0, 0});
        vt.push_back('{"wr_grant3", 0, 4'b1000, 0, 1, 1, 4'b0000, 2'd3, 1, 0});
        vt.push_back('{"wr_ack3",   0, 4'b1000, 1, 3, 1, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{"wr_reqlo3", 0, 4'b0000, 1, 3, 0, 4'b1000, 2'd3, 1, 0});
        vt.push_back('{"wr_done",   0, 4'b0000, 0, 3, 0, 4'b0000, 2'd3, 0, 0});

        foreach (vt[i]) begin
            rst     = vt[i].rst;
            req_in  = vt[i].req;
            ack_out = vt[i].ack;
            edges(vt[i].edges);
            chk_all(vt[i].name, vt[i].ro, vt[i].ai, vt[i].gid, vt[i].busy, vt[i].err);
        end

        // Downstream ack while idle: sticky error, arbiter stays idle.
        do_reset();
        ack_out = 1'b1;
        edges(2);
        chk("perr_idle_e2", 32'(proto_err), 32'd0);
        edges(1);
        chk("perr_idle_e3", 32'(proto_err), 32'd1);
        ack_out = 1'b0;
        edges(10);
        chk("perr_sticky", 32'(proto_err), 32'd1);
        chk("perr_busy",   32'(busy),      32'd0);
        do_reset();
        chk("perr_cleared", 32'(proto_err), 32'd0);

        // Requester withdraws before downstream acks: error, FSM keeps waiting.
        req_in = 4'b0001;
        edges(3);
        chk("perr_reqhi_grant", 32'(req_out), 32'd1);
        req_in = 4'b0000;
        edges(3);
        chk("perr_reqhi_err",  32'(proto_err), 32'd1);
        chk("perr_reqhi_busy", 32'(busy),      32'd1);
        do_reset();

        // Reset in ACK_HI aborts at once; requester 0 wins first afterwards.
        req_in = 4'b0100;
        edges(3);
        ack_out = 1'b1;
        edges(3);
        req_in = 4'b0101;
        chk("rmid_in_ackhi", 32'(ack_in), 32'h4);
        rst = 1'b1; ack_out = 1'b0;
        edges(1);
        chk_all("rmid_abort", 0, 4'b0000, 2'd0, 0, 0);
        rst = 1'b0; req_in = 4'b0011;
        edges(2);
        chk("rmid_lat2", 32'(req_out), 32'd0);
        edges(1);
        chk_all("rmid_regrant", 1, 4'b0000, 2'd0, 1, 0);
        do_reset();

        // One-cycle pulse on requester 1 while busy with 0 is dropped.
        req_in = 4'b0001;
        edges(3);
        ack_out = 1'b1;
        edges(3);
        chk("gl_ackhi", 32'(ack_in), 32'h1);
        req_in = 4'b0011;
        edges(1);
        req_in = 4'b0001;
        edges(5);
        req_in = 4'b0000;
        edges(3);
        ack_out = 1'b0;
        edges(3);
        chk_all("gl_done", 0, 4'b0000, 2'd0, 0, 0);
        edges(4);
        chk_all("gl_no_grant1", 0, 4'b0000, 2'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_arbiter.md
HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of 4-phase requester channels (2..16).
REQ-002 Parameter SYNC_STAGES, default 2, flop depth of each input synchronizer (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 req_in  input  N_REQ  per-requester 4-phase request, asynchronous to clk (driven by fork/muller logic).
REQ-006 ack_in  output  N_REQ  per-requester acknowledge, registered.
REQ-007 req_out  output  1  request to the shared downstream channel (fork_neuron req_in), registered.
REQ-008 ack_out  input  1  acknowledge from the shared downstream channel, asynchronous to clk.
REQ-009 grant_id  output  $clog2(N_REQ)  index of the current or last granted requester, registered.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 proto_err  output  1  sticky protocol-violation flag.

Function
REQ-012 Each req_in bit and ack_out SHALL pass through a SYNC_STAGES-deep flop synchronizer; the FSM SHALL use only synchronized values (sreq, sack).
REQ-013 FSM states SHALL be IDLE, REQ_HI, ACK_HI, REQ_LO, one-hot or binary, registered.
REQ-014 IDLE: if any sreq bit is high, the FSM SHALL choose the first high bit searching round-robin from last_grant+1 (modulo N_REQ), load grant_id, set req_out=1, and go to REQ_HI; otherwise it SHALL stay in IDLE.
REQ-015 REQ_HI: on sack=1, set ack_in[grant_id]=1 and go to ACK_HI.
REQ-016 ACK_HI: on sreq[grant_id]=0, set req_out=0 and go to REQ_LO.
REQ-017 REQ_LO: on sack=0, set ack_in[grant_id]=0, set last_grant=grant_id, and go to IDLE.
REQ-018 At most one ack_in bit SHALL be high at any time; ack_in bits of non-granted requesters SHALL stay 0.
REQ-019 Latency: req_out SHALL rise exactly SYNC_STAGES+1 clk edges after a req_in rise that is stable before the first synchronizer edge, when the FSM is in IDLE and that requester wins.
REQ-020 Each handshake transition SHALL add exactly SYNC_STAGES+1 edges of latency (input change -> registered output change).
REQ-021 Round-robin wrap: after last_grant=N_REQ-1 the search SHALL start at index 0.
REQ-022 Requests that rise and fall while the FSM is not in IDLE SHALL be ignored; no request queueing.
REQ-023 Simultaneous requests: exactly one SHALL be granted per transaction; the others SHALL stay pending, with no ack_in.
REQ-024 proto_err SHALL be set on sack=1 in IDLE, or on sreq[grant_id]=0 in REQ_HI; the FSM SHALL continue normally after the error.
REQ-025 proto_err SHALL clear only on rst.

Reset
REQ-026 On rst=1, FSM=IDLE, req_out=0, ack_in=0, grant_id=0, busy=0, proto_err=0, and all synchronizer flops=0.
REQ-027 On rst=1, last_grant SHALL be N_REQ-1 so that requester 0 has first priority.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction immediately on that edge, with no completion of pending phases.

Structure
REQ-029 Package handshake_arb_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-030 A sub-module sync_bit (SYNC_STAGES flop chain, clk/rst) SHALL be instantiated N_REQ+1 times.
REQ-031 The round-robin select SHALL be a function inside handshake_arbiter, not a separate module.

Verification
REQ-032 Single request: N_REQ=4, raise req_in[2]; req_out=1 after 3 edges; drive ack_out=1; ack_in[2]=1 after 3 edges; full 4-phase completes; last_grant=2.
REQ-033 Contention: after reset, raise req_in=4'b1010; grant_id=1 first, then grant_id=3 on the next transaction; ack_in is never 2 bits high.
REQ-034 Wrap: last_grant=3, req_in=4'b1001 -> grant_id=0, then 3.
REQ-035 Protocol error: ack_out=1 while idle -> proto_err=1 within 3 edges and remains 1 until rst.
REQ-036 Reset mid-operation: assert rst in ACK_HI -> next edge req_out=0, ack_in=0, busy=0; with req_in[0] still high, the first grant after reset is requester 0.
REQ-037 Glitch ignore: pulse req_in[1] for 1 cycle while busy with requester 0 -> no grant to requester 1.
